y_run_encoder: RTL and testbench

Y_RUN_ENCODER -- requirements
Module: y_run_encoder

---
 rtl/y_run_pkg.sv | 16 +
 rtl/y_run_encoder_if.sv | 25 ++
 rtl/y_run_fifo.sv | 46 ++++
 rtl/y_run_encoder.sv | 99 +++++++++
 tb/tb_y_run_encoder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/y_run_pkg.sv
// Shared types for the run-length encoder: FSM states and the run record layout.
package y_run_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 val;
    logic [LEN_W_DEF-1:0] len;
  } rec_t;

endpackage

// File: rtl/y_run_encoder_if.sv
// Record output channel of the run-length encoder: valid/ready handshake carrying one run record.
interface y_run_encoder_if #(
  parameter int LEN_W = 8
);

  logic             out_valid;
  logic             out_ready;
  logic             out_val;
  logic [LEN_W-1:0] out_len;

  modport master (
    output out_valid,
    output out_val,
    output out_len,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_val,
    input  out_len,
    output out_ready
  );

endinterface

// File: rtl/y_run_fifo.sv
// Generic synchronous FIFO with registered storage; head shows one cycle after the write, no bypass.
// A push while full is accepted only if a pop happens at the same edge; otherwise it is ignored.
module y_run_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/y_run_encoder.sv
// Run-length encoder for the serial Y stream: records pushed at the deciding edge, visible next cycle.
// Records queue in a small FIFO; when it is full and not draining, the record is dropped and drop_err sticks.
module y_run_encoder
  import y_run_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    Y,
  y_run_encoder_if.master         rec_bus,
  output logic                    drop_err,
  output logic [15:0]             rec_cnt
);

  typedef struct packed {
    logic             val;
    logic [LEN_W-1:0] len;
  } rec_w_t;

  localparam logic [LEN_W-1:0] RMAX = '1;
  localparam logic [LEN_W-1:0] ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             cur_val;
  logic [LEN_W-1:0] cnt;
  logic             push;
  logic             accept;
  logic             full;
  logic             empty;
  rec_w_t           wr_rec;
  rec_w_t           rd_rec;

  // A run closes on disable, on a level change, or when it reaches the longest encodable length.
  assign push   = (state == RUN) && (!en || (Y != cur_val) || (cnt == RMAX));
  assign wr_rec = '{val: cur_val, len: cnt};
  assign accept = push && (!full || (rec_bus.out_valid && rec_bus.out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_val <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            cur_val <= Y;
            cnt     <= ONE;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if ((Y != cur_val) || (cnt == RMAX)) begin
            cur_val <= Y;
            cnt     <= ONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      rec_cnt  <= '0;
    end else begin
      if (accept)          rec_cnt  <= rec_cnt + 16'd1;
      if (push && !accept) drop_err <= 1'b1;
    end
  end

  y_run_fifo #(
    .DW    ($bits(rec_w_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rec_bus.out_ready),
    .wdata (wr_rec),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty)
  );

  assign rec_bus.out_valid = !empty;
  assign rec_bus.out_val   = rd_rec.val;
  assign rec_bus.out_len   = rd_rec.len;

endmodule

// File: tb/tb_y_run_encoder.sv
// Bench for y_run_encoder: directed scenarios with literal expectations plus a random run against a queue model.
module tb_y_run_encoder;
  import y_run_pkg::*;

  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int RMAX  = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        Y;
  logic        ready;
  logic        drop_err;
  logic [15:0] rec_cnt;

  y_run_encoder_if #(.LEN_W(LW)) bus ();
  assign bus.out_ready = ready;

  y_run_encoder #(
    .LEN_W      (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .Y        (Y),
    .rec_bus  (bus),
    .drop_err (drop_err),
    .rec_cnt  (rec_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: current run as plain integers, FIFO as a bounded queue.
  rec_t        mq[$];
  rec_t        got[$];
  bit          m_act;
  bit          m_val;
  int          m_len;
  logic [15:0] m_cnt;
  bit          m_drop;
  bit          m_emit;
  rec_t        m_rec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input bit v, input int l);
    rec_t r;
    r.val = v;
    r.len = l[LW-1:0];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_act  = 0;
      m_val  = 0;
      m_len  = 0;
      m_cnt  = '0;
      m_drop = 0;
    end else begin
      m_emit = 0;
      m_rec  = mk(m_val, m_len);
      if (!m_act) begin
        if (en) begin
          m_act = 1;
          m_val = Y;
          m_len = 1;
        end
      end else if (!en) begin
        m_emit = 1;
        m_act  = 0;
      end else if (Y != m_val) begin
        m_emit = 1;
        m_val  = Y;
        m_len  = 1;
      end else if (m_len == RMAX) begin
        m_emit = 1;
        m_len  = 1;
      end else begin
        m_len++;
      end
      if (ready && mq.size() > 0) void'(mq.pop_front());
      if (m_emit) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(m_rec);
          m_cnt++;
        end else begin
          m_drop = 1;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge, plus a log of every record the consumer takes.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_val", 32'(bus.out_val), 32'(mq[0].val));
        chk("out_len", 32'(bus.out_len), 32'(mq[0].len));
      end
      chk("rec_cnt", 32'(rec_cnt), 32'(m_cnt));
      chk("drop_err", 32'(drop_err), 32'(m_drop));
      if (bus.out_valid && ready) got.push_back(mk(bus.out_val, int'(bus.out_len)));
    end
  end

  task automatic step(input bit en_v, input bit y_v, input bit rdy_v);
    en    = en_v;
    Y     = y_v;
    ready = rdy_v;
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_val"},   32'(bus.out_val),   32'd0);
    chk({tag, "_len"},   32'(bus.out_len),   32'd0);
    chk({tag, "_drop"},  32'(drop_err),      32'd0);
    chk({tag, "_cnt"},   32'(rec_cnt),       32'd0);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("rst");
    @(posedge clk);
    #2;
    got.delete();
    rst_n = 1'b1;
  endtask

  bit yr;
  bit er;
  bit rr;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    Y     = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Five highs, three lows, then disable.
    repeat (5) step(1, 1, 1);
    repeat (3) step(1, 0, 1);
    repeat (4) step(0, 0, 1);
    chk("t1_count", 32'(got.size()), 32'd2);
    chk("t1_rec0", 32'(got[0]), 32'(mk(1, 5)));
    chk("t1_rec1", 32'(got[1]), 32'(mk(0, 3)));
    chk("t1_rec_cnt", 32'(rec_cnt), 32'd2);
    chk("t1_model_cnt", 32'(m_cnt), 32'd2);
    chk("t1_drop", 32'(drop_err), 32'd0);

    // 300 highs: saturating split at the 256th edge.
    do_reset();
    repeat (255) step(1, 1, 1);
    chk("t2_pre_sat_valid", 32'(bus.out_valid), 32'd0);
    step(1, 1, 1);
    chk("t2_sat_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_sat_len", 32'(bus.out_len), 32'd255);
    repeat (44) step(1, 1, 1);
    step(1, 0, 1);
    repeat (4) step(0, 0, 1);
    chk("t2_rec0", 32'(got[0]), 32'(mk(1, 255)));
    chk("t2_rec1", 32'(got[1]), 32'(mk(1, 45)));
    chk("t2_rec2", 32'(got[2]), 32'(mk(0, 1)));

    // Stalled consumer with a toggling input: overflow and a stable head.
    do_reset();
    step(1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, bit'(i % 2), 0);
      chk("t3_head_val", 32'(bus.out_val), 32'd0);
      chk("t3_head_len", 32'(bus.out_len), 32'd1);
    end
    step(0, 0, 0);
    chk("t3_rec_cnt", 32'(rec_cnt), 32'd4);
    chk("t3_drop", 32'(drop_err), 32'd1);
    chk("t3_model_drop", 32'(m_drop), 32'd1);
    repeat (6) step(0, 0, 1);
    chk("t3_count", 32'(got.size()), 32'd4);
    chk("t3_rec0", 32'(got[0]), 32'(mk(0, 1)));
    chk("t3_rec1", 32'(got[1]), 32'(mk(1, 1)));
    chk("t3_rec2", 32'(got[2]), 32'(mk(0, 1)));
    chk("t3_rec3", 32'(got[3]), 32'(mk(1, 1)));
    chk("t3_empty", 32'(bus.out_valid), 32'd0);

    // Full FIFO with push and pop at the same edge.
    do_reset();
    step(1, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, bit'(i % 2), 0);
    chk("t4_full_cnt", 32'(rec_cnt), 32'd4);
    step(1, 1, 1);
    chk("t4_pp_cnt", 32'(rec_cnt), 32'd5);
    chk("t4_pp_drop", 32'(drop_err), 32'd0);
    repeat (3) step(1, 1, 0);
    repeat (6) step(1, 1, 1);
    chk("t4_count", 32'(got.size()), 32'd5);
    chk("t4_rec1", 32'(got[1]), 32'(mk(1, 1)));
    chk("t4_rec4", 32'(got[4]), 32'(mk(0, 1)));
    chk("t4_empty", 32'(bus.out_valid), 32'd0);
    chk("t4_drop", 32'(drop_err), 32'd0);

    // Reset in the middle of a run with two records buffered.
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t5_buffered_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_buffered_cnt", 32'(rec_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_cnt", 32'(rec_cnt), 32'd0);
    en = 1'b0;
    @(posedge clk);
    #2;
    got.delete();
    rst_n = 1'b1;
    repeat (5) step(0, 1, 1);
    chk("t5_quiet_count", 32'(got.size()), 32'd0);
    chk("t5_quiet_valid", 32'(bus.out_valid), 32'd0);
    step(1, 1, 1);
    step(1, 1, 1);
    repeat (2) step(0, 0, 1);
    chk("t5_count", 32'(got.size()), 32'd1);
    chk("t5_rec0", 32'(got[0]), 32'(mk(1, 2)));

    // Random traffic with long-run windows and a variable consumer.
    do_reset();
    yr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      er = ($urandom_range(0, 19) != 0);
      if ((i % 700) >= 300 && $urandom_range(0, 5) == 0) yr = ~yr;
      if (i < 1500) rr = bit'($urandom_range(0, 1));
      else          rr = ($urandom_range(0, 9) != 0);
      step(er, yr, rr);
    end
    repeat (8) step(0, 0, 1);
    chk("t6_drained", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
